// File: rtl/spi_prog_slave_if.sv
// ---------------------------------------------------------------------------
// spi_prog_slave_if
// Purpose : groups the SPI pins and the byte-wide program-memory port of the
//           SPI programming slave into one bundle.
// Signals : sclk/ss_n/mosi/miso - SPI mode 0 link to the bench master
//           mem_addr/mem_wdata/mem_we/mem_re/mem_rdata - program memory port
//           busy/wr_done - transaction status
// Modports: slave  - the spi_prog_slave side
//           master - the environment side (SPI master plus memory)
// ---------------------------------------------------------------------------
interface spi_prog_slave_if #(
  parameter int ADDR_W = 8
);
  logic              sclk;
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              wr_done;

  modport slave (
    input  sclk, ss_n, mosi, mem_rdata,
    output miso, mem_addr, mem_wdata, mem_we, mem_re, busy, wr_done
  );

  modport master (
    output sclk, ss_n, mosi, mem_rdata,
    input  miso, mem_addr, mem_wdata, mem_we, mem_re, busy, wr_done
  );
endinterface

// File: rtl/spi_prog_slave.sv
// ---------------------------------------------------------------------------
// spi_prog_slave
// Purpose : SPI mode 0 slave decoding a flash-style protocol (0x02 write,
//           0x03 read, 4-byte big-endian address, auto-increment data stream)
//           into byte accesses on the program memory port. Every SPI pin is
//           oversampled in the sys_clk domain; nothing runs on sclk.
// Ports   : sys_clk   - system clock, at least 8x the SCLK rate
//           sys_rst_n - asynchronous active-low reset
//           bus       - spi_prog_slave_if.slave (SPI pins, memory port,
//                       busy and wr_done status)
// ---------------------------------------------------------------------------
module spi_prog_slave #(
  parameter int ADDR_W = 8
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  spi_prog_slave_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_WDATA, ST_RDATA, ST_IGNORE
  } state_t;

  state_t            r_state;
  logic              r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic              r_ss_s1, r_ss_s2;
  logic              r_mosi_s1, r_mosi_s2;
  logic              r_armed;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_rx;
  logic [7:0]        r_byte;
  logic              r_byte_vld;
  logic [31:0]       r_addr;
  logic [1:0]        r_addr_cnt;
  logic              r_write;
  logic              r_wrote;
  logic [7:0]        r_tx_buf;
  logic [7:0]        r_tx_shift;
  logic              r_re_d;
  logic              r_miso;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_re;
  logic              r_busy;
  logic              r_wr_done;

  logic              w_rise;
  logic              w_fall;
  logic [31:0]       w_addr_next;
  logic [31:0]       w_addr_inc;

  assign w_rise      = r_sclk_s2 & ~r_sclk_s3;
  assign w_fall      = ~r_sclk_s2 & r_sclk_s3;
  assign w_addr_next = {r_addr[23:0], r_byte};
  assign w_addr_inc  = r_addr + 32'd1;

  assign bus.miso      = r_miso;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;
  assign bus.busy      = r_busy;
  assign bus.wr_done   = r_wr_done;

  // Two-flop synchronisers plus a third sclk stage for edge detection.
  // ss_n resets to "selected" so the block cannot arm until a genuine high
  // level on ss_n has travelled through the synchroniser.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_ss_s1   <= 1'b0;
      r_ss_s2   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= bus.sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_ss_s1   <= bus.ss_n;
      r_ss_s2   <= r_ss_s1;
      r_mosi_s1 <= bus.mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // Receive shifter. A completed byte is handed to the FSM through r_byte
  // with a one-cycle valid, which is the extra stage that places the memory
  // strobes on the third edge after sclk is first sampled high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bit_cnt  <= 3'd0;
      r_rx       <= 8'h00;
      r_byte     <= 8'h00;
      r_byte_vld <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_bit_cnt <= 3'd0;
      end else if (w_rise) begin
        r_rx      <= {r_rx[6:0], r_mosi_s2};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte     <= {r_rx[6:0], r_mosi_s2};
          r_byte_vld <= 1'b1;
        end
      end
    end
  end

  // Protocol FSM with registered memory strobes and status. Deselect wins
  // over any byte arriving in the same cycle, so a partial or late byte is
  // never committed. r_armed keeps a frame that was cut by reset from being
  // picked up halfway through.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b0;
      r_addr      <= 32'd0;
      r_addr_cnt  <= 2'd0;
      r_write     <= 1'b0;
      r_wrote     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_mem_we  <= 1'b0;
      r_mem_re  <= 1'b0;
      r_wr_done <= 1'b0;
      if (r_ss_s2) r_armed <= 1'b1;
      if (r_state != ST_IDLE && r_ss_s2) begin
        r_state   <= ST_IDLE;
        r_busy    <= 1'b0;
        r_wr_done <= r_write & r_wrote;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_armed && !r_ss_s2) begin
              r_state    <= ST_CMD;
              r_busy     <= 1'b1;
              r_addr_cnt <= 2'd0;
              r_write    <= 1'b0;
              r_wrote    <= 1'b0;
            end
          end
          ST_CMD: begin
            if (r_byte_vld) begin
              case (r_byte)
                8'h02: begin r_state <= ST_ADDR; r_write <= 1'b1; end
                8'h03: begin r_state <= ST_ADDR; r_write <= 1'b0; end
                default: r_state <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            if (r_byte_vld) begin
              r_addr     <= w_addr_next;
              r_addr_cnt <= r_addr_cnt + 2'd1;
              if (r_addr_cnt == 2'd3) begin
                if (r_write) begin
                  r_state <= ST_WDATA;
                end else begin
                  // Prefetch the first read byte while the dummy byte runs.
                  r_state    <= ST_DUMMY;
                  r_mem_addr <= w_addr_next[ADDR_W-1:0];
                  r_mem_re   <= 1'b1;
                end
              end
            end
          end
          ST_DUMMY: begin
            if (r_byte_vld) r_state <= ST_RDATA;
          end
          ST_WDATA: begin
            if (r_byte_vld) begin
              r_mem_we    <= 1'b1;
              r_mem_wdata <= r_byte;
              r_mem_addr  <= r_addr[ADDR_W-1:0];
              r_addr      <= w_addr_inc;
              r_wrote     <= 1'b1;
            end
          end
          ST_RDATA: begin
            if (r_byte_vld) begin
              r_addr     <= w_addr_inc;
              r_mem_addr <= w_addr_inc[ADDR_W-1:0];
              r_mem_re   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Transmit path. Read data arrives one cycle after mem_re and is parked in
  // r_tx_buf; the falling edge that starts a byte (bit_cnt back at 0) moves
  // it into the shifter. miso is registered from the shifter's next MSB.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_re_d     <= 1'b0;
      r_tx_buf   <= 8'h00;
      r_tx_shift <= 8'h00;
      r_miso     <= 1'b0;
    end else begin
      r_re_d <= r_mem_re;
      if (r_re_d) r_tx_buf <= bus.mem_rdata;
      if (r_state != ST_RDATA) begin
        r_tx_shift <= 8'h00;
        r_miso     <= 1'b0;
      end else if (w_fall) begin
        if (r_bit_cnt == 3'd0) begin
          r_tx_shift <= r_tx_buf;
          r_miso     <= r_tx_buf[7];
        end else begin
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          r_miso     <= r_tx_shift[6];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_prog_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_prog_slave
// Purpose : drives spi_prog_slave as an SPI mode 0 master plus a synchronous
//           program memory, and compares memory writes, read-back bytes and
//           status pulses against a frame-level model of the memory image.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_prog_slave;
  localparam int ADDR_W = 8;
  localparam int MEM_SZ = 1 << ADDR_W;
  localparam int HALF   = 50;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  spi_prog_slave_if #(.ADDR_W(ADDR_W)) bus ();

  spi_prog_slave #(.ADDR_W(ADDR_W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  // 100 MHz system clock; SPI edges are placed 2 ns after a negedge.
  always #5 sys_clk = ~sys_clk;

  // Synchronous program memory: read data valid the cycle after mem_re.
  logic [7:0] ram [MEM_SZ];
  logic       ramClear = 1'b1;
  always @(posedge sys_clk) begin
    if (ramClear) begin
      for (int i = 0; i < MEM_SZ; i++) ram[i] <= 8'h00;
      bus.mem_rdata <= 8'h00;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // Passive monitor of the memory port and status pins.
  logic [7:0] obsAddr[$];
  logic [7:0] obsData[$];
  int   reCount     = 0;
  int   wrDoneCount = 0;
  int   bothCount   = 0;
  int   misoBad     = 0;
  logic zeroWin     = 1'b1;
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bus.mem_we) begin
        obsAddr.push_back(bus.mem_addr);
        obsData.push_back(bus.mem_wdata);
      end
      if (bus.mem_re) reCount++;
      if (bus.wr_done) wrDoneCount++;
      if (bus.mem_we && bus.mem_re) bothCount++;
      if (zeroWin && bus.miso) misoBad++;
    end
  end

  // Reference model: the memory image the master believes it has written.
  logic [7:0] expMem [MEM_SZ];
  logic [7:0] txData[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spiByte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = tx[i];
      #HALF;
      bus.sclk = 1'b1;
      rx[i] = bus.miso;
      #HALF;
      bus.sclk = 1'b0;
    end
  endtask

  task automatic spiBits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.mosi = tx[i];
      #HALF;
      bus.sclk = 1'b1;
      #HALF;
      bus.sclk = 1'b0;
    end
  endtask

  task automatic ssLow();
    bus.ss_n = 1'b0;
    #60;
  endtask

  task automatic ssHigh();
    #30;
    bus.ss_n = 1'b1;
    #80;
  endtask

  task automatic sendHeader(input logic [7:0] cmd, input logic [31:0] addr, output int reMid);
    logic [7:0] rx;
    spiByte(cmd, rx);
    spiByte(addr[31:24], rx);
    spiByte(addr[23:16], rx);
    spiByte(addr[15:8], rx);
    reMid = reCount;
    spiByte(addr[7:0], rx);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_miso"},    bus.miso, 0);
    checkOutput({tag, "_addr"},    bus.mem_addr, 0);
    checkOutput({tag, "_wdata"},   bus.mem_wdata, 0);
    checkOutput({tag, "_we"},      bus.mem_we, 0);
    checkOutput({tag, "_re"},      bus.mem_re, 0);
    checkOutput({tag, "_busy"},    bus.busy, 0);
    checkOutput({tag, "_wr_done"}, bus.wr_done, 0);
  endtask

  // One complete write frame (data from txData) or read frame of len bytes.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input int len);
    logic [7:0]  rx;
    logic [31:0] a;
    int wBase, reBase, wdBase, reMid;
    wBase  = obsAddr.size();
    reBase = reCount;
    wdBase = wrDoneCount;
    ssLow();
    sendHeader(isWrite ? 8'h02 : 8'h03, addr, reMid);
    if (isWrite) begin
      for (int i = 0; i < len; i++) begin
        spiByte(txData[i], rx);
        a = addr + 32'(i);
        expMem[a[ADDR_W-1:0]] = txData[i];
      end
      ssHigh();
      checkOutput("wr_count", obsAddr.size() - wBase, len);
      for (int i = 0; i < len; i++) begin
        a = addr + 32'(i);
        if (wBase + i < obsAddr.size()) begin
          checkOutput("wr_addr", obsAddr[wBase+i], a[ADDR_W-1:0]);
          checkOutput("wr_data", obsData[wBase+i], txData[i]);
        end
      end
      checkOutput("wr_done", wrDoneCount - wdBase, (len > 0) ? 1 : 0);
      checkOutput("wr_no_re", reCount - reBase, 0);
    end else begin
      checkOutput("re_before_addr", reMid - reBase, 0);
      checkOutput("re_after_addr", reCount - reBase, 1);
      spiByte(8'h00, rx);
      zeroWin = 1'b0;
      for (int i = 0; i < len; i++) begin
        spiByte(8'($urandom), rx);
        a = addr + 32'(i);
        checkOutput("rd_data", rx, expMem[a[ADDR_W-1:0]]);
      end
      ssHigh();
      zeroWin = 1'b1;
      checkOutput("rd_re_total", reCount - reBase, 1 + len);
      checkOutput("rd_no_we", obsAddr.size() - wBase, 0);
      checkOutput("rd_no_wr_done", wrDoneCount - wdBase, 0);
    end
  endtask

  initial begin
    logic [7:0]  rx;
    logic [31:0] addr;
    int wBase, reBase, wdBase, reMid, len, dropAt;

    bus.sclk = 1'b0;
    bus.ss_n = 1'b1;
    bus.mosi = 1'b0;
    for (int i = 0; i < MEM_SZ; i++) expMem[i] = 8'h00;

    #22;
    checkReset("reset");
    sys_rst_n = 1'b1;
    ramClear  = 1'b0;
    #40;

    // Write stream, then read it back.
    txData.delete();
    for (int i = 1; i <= 50; i++) txData.push_back(8'(i));
    applyStimulus(1'b1, 32'h04030201, 50);
    applyStimulus(1'b0, 32'h04030201, 50);

    // Address wrap at the top of the memory.
    txData.delete();
    txData.push_back(8'hAA);
    txData.push_back(8'hBB);
    applyStimulus(1'b1, 32'h000000FF, 2);
    applyStimulus(1'b0, 32'h000000FF, 2);

    // Unknown command: the frame must be ignored completely.
    wBase = obsAddr.size(); reBase = reCount; wdBase = wrDoneCount;
    ssLow();
    spiByte(8'h9F, rx);
    for (int i = 0; i < 8; i++) spiByte(8'($urandom), rx);
    ssHigh();
    checkOutput("unk_we", obsAddr.size() - wBase, 0);
    checkOutput("unk_re", reCount - reBase, 0);
    checkOutput("unk_wr_done", wrDoneCount - wdBase, 0);

    // Abort after 5 bits of the 4th data byte.
    addr = {$urandom} & 32'hFFFF_FFF0;
    wBase = obsAddr.size(); wdBase = wrDoneCount;
    txData.delete();
    for (int i = 0; i < 4; i++) txData.push_back(8'($urandom_range(1, 255)));
    ssLow();
    sendHeader(8'h02, addr, reMid);
    for (int i = 0; i < 3; i++) begin
      spiByte(txData[i], rx);
      expMem[8'(addr[ADDR_W-1:0] + 8'(i))] = txData[i];
    end
    spiBits(txData[3], 5);
    #30;
    bus.ss_n = 1'b1;
    dropAt = 99;
    for (int c = 1; c <= 10; c++) begin
      @(negedge sys_clk);
      if (!bus.busy) begin
        dropAt = c;
        break;
      end
    end
    #2;
    #80;
    checkOutput("abort_busy_drop", (dropAt <= 3) ? 1 : 0, 1);
    checkOutput("abort_wr_count", obsAddr.size() - wBase, 3);
    checkOutput("abort_wr_done", wrDoneCount - wdBase, 1);
    applyStimulus(1'b0, addr, 4);

    // Reset during the address phase, frame continues with ss_n still low.
    ssLow();
    spiByte(8'h02, rx);
    spiByte(8'h00, rx);
    spiByte(8'h00, rx);
    sys_rst_n = 1'b0;
    #1;
    checkReset("midrst");
    #19;
    sys_rst_n = 1'b1;
    wBase = obsAddr.size();
    spiByte(8'h00, rx);
    spiByte(8'h10, rx);
    for (int i = 0; i < 3; i++) spiByte(8'h5A, rx);
    checkOutput("midrst_busy", bus.busy, 0);
    ssHigh();
    checkOutput("midrst_no_we", obsAddr.size() - wBase, 0);
    txData.delete();
    for (int i = 0; i < 3; i++) txData.push_back(8'($urandom));
    applyStimulus(1'b1, 32'h00000010, 3);
    applyStimulus(1'b0, 32'h00000010, 3);

    // Randomised write/read frames plus reads of arbitrary regions.
    for (int n = 0; n < 6; n++) begin
      addr = $urandom;
      len  = $urandom_range(1, 12);
      txData.delete();
      for (int i = 0; i < len; i++) txData.push_back(8'($urandom));
      applyStimulus(1'b1, addr, len);
      applyStimulus(1'b0, addr, len);
      applyStimulus(1'b0, $urandom, 4);
    end

    checkOutput("we_re_overlap", bothCount, 0);
    checkOutput("miso_outside_rdata", misoBad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_prog_slave.md
# spi_prog_slave

SPI slave that accepts the programming/readback traffic produced by the bench SPI master and turns it into byte-wide accesses on the 8-bit computer's program memory port. It sits directly downstream of the SPI master and upstream of the memory. It decodes a flash-style protocol: write 0x02 and read 0x03, each followed by a 4-byte address and then a data stream with address auto-increment. All SPI pins are oversampled in the `sys_clk` domain; there is no logic clocked by `sclk`.

## Interface
- `ADDR_W`, default 8: width of `mem_addr`. It is the low `ADDR_W` bits of a 32-bit internal address register.
- `sys_clk` in 1: system clock. Must be at least 8× the SCLK frequency.
- `sys_rst_n` in 1: reset, asynchronous assert, active-low (already decided).
- `sclk` in 1: SPI clock, mode 0 (idle low, sample on rising edge, shift on falling edge), MSB first. Asynchronous to `sys_clk`.
- `ss_n` in 1: SPI chip select, active-low. Asynchronous.
- `mosi` in 1: master-out data. Asynchronous.
- `miso` out 1: slave-out data.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out 8: write data.
- `mem_we` out 1: write strobe, one cycle wide.
- `mem_re` out 1: read strobe, one cycle wide.
- `mem_rdata` in 8: read data, valid exactly 1 cycle after `mem_re`.
- `busy` out 1: high while a transaction is selected (state ≠ IDLE).
- `wr_done` out 1: one-cycle pulse when `ss_n` deasserts after a write transaction that committed at least one byte.

## Operation
- **Synchronisers.** `sclk`, `ss_n` and `mosi` each pass through a 2-flop synchroniser. A 3rd `sclk` stage provides edge detection.
  - `rise` = s2 & ~s3.
  - `fall` = ~s2 & s3.
  - Rising-edge sampling uses the synchronised `mosi`, which has the same delay as `sclk`.
- **Bit counter.** `bit_cnt` (0..7) counts rising edges within the current byte. The shift register takes `{rx[6:0], mosi}`. The byte is complete on the rise where `bit_cnt` is 7, and `bit_cnt` then wraps to 0.
- **FSM states:** IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE.
  - IDLE → CMD when synchronised `ss_n` is low. `bit_cnt` and the address byte counter are cleared on entry.
  - CMD, on byte complete:
    - 0x02 → ADDR with write flag set.
    - 0x03 → ADDR with write flag clear.
    - Any other value → IGNORE.
  - ADDR: collects 4 bytes, big-endian, into `addr[31:0]`. After the 4th byte:
    - Write → WDATA.
    - Read → DUMMY, and issue `mem_re` for `addr` (prefetch into `tx_buf`).
  - DUMMY → RDATA on byte complete. The dummy byte content is discarded.
  - WDATA, per completed byte:
    - `mem_wdata` = byte, `mem_addr` = `addr`, `mem_we` = 1 for one cycle.
    - Then `addr` += 1.
  - RDATA, per completed byte: `addr` += 1, then `mem_re` for the new `addr`. The returned data is latched into `tx_buf`.
  - IGNORE: discards all bits. `miso` = 0.
  - Any state → IDLE when synchronised `ss_n` is high. A partial byte is discarded with no write. `wr_done` pulses if the write flag is set and at least one byte was written.
- **Transmit path.**
  - On `fall` in RDATA with `bit_cnt` = 0, `tx_shift` loads `tx_buf`.
  - On other `fall` events in RDATA, `tx_shift` shifts left.
  - `miso` = `tx_shift[7]` in RDATA and 0 in all other states.
  - The first read byte on `miso` is therefore `mem[start addr]`, presented on the falling edge that ends the dummy byte.
- **Address wrap.** `addr` increments modulo 2^32. `mem_addr` wraps modulo 2^`ADDR_W`, so 0xFF → 0x00 when `ADDR_W` = 8.

## Timing
- **Reset values:** `miso` 0, `mem_addr` 0, `mem_wdata` 0, `mem_we` 0, `mem_re` 0, `busy` 0, `wr_done` 0. The FSM is in IDLE and `tx_shift`/`tx_buf` are 0.
- **Async reset.** Asserting `sys_rst_n` mid-transfer clears everything immediately. After release, the block waits for `ss_n` high before it accepts a new transaction; it never resumes mid-frame.
- **Write latency.** `mem_we` asserts at the 3rd `sys_clk` edge after the edge that first samples `sclk` high on the last bit of a byte.
- **Read latency.** `mem_re` follows the same 3-edge latency. `tx_buf` is updated 1 cycle later.
- **Host timing requirements:**
  - `sclk` high and low phases ≥ 4 `sys_clk` periods each.
  - `ss_n` low ≥ 4 cycles before the first `sclk` rise.
  - `ss_n` high ≥ 4 cycles between frames.
- **`miso` timing.** `miso` changes no later than 3 `sys_clk` cycles after the `sclk` falling edge, which makes it stable before the next rise.
- **Strobes.** `mem_we` and `mem_re` are never high in the same cycle. Each is exactly 1 cycle per byte.

## Test plan
- **Write stream.** Cmd 0x02, addr 0x04030201, 50 bytes 0x01..0x32 (`ADDR_W` = 8) → 50 `mem_we` pulses at `mem_addr` 0x01..0x32 with data 0x01..0x32. Single `wr_done` pulse after `ss_n` rises.
- **Read back.** Cmd 0x03, same addr, dummy 0x00, 50 bytes clocked → master receives 0x01..0x32 on `miso`. First `mem_re` comes after the 4th address byte. `miso` = 0 throughout cmd/addr/dummy.
- **Wrap.** Write at addr 0x000000FF with bytes 0xAA, 0xBB → writes FF←AA, then 00←BB.
- **Unknown command.** Cmd 0x9F followed by 8 bytes → no `mem_we`/`mem_re`, `miso` stays 0, no `wr_done`.
- **Abort.** `ss_n` raised after 5 bits of a write data byte → no write for the partial byte. Earlier complete bytes remain written. `busy` drops within 3 cycles. The next frame decodes cleanly.
- **Reset mid-frame.** `sys_rst_n` pulsed low during address phase → all outputs are at reset values immediately. A subsequent full write frame with `ss_n` high-then-low works correctly.
